prio_enc_arb: RTL
=================

Name: prio_enc_arb

Overview:
- Parametrised, registered successor to the combinational 4-to-2 priority encoder.
- Latches single-cycle request events from N sources into a pending vector.
- Presents one pending index at a time on a valid/ready output. Selection is fixed-priority (highest index wins) or round-robin.
- Sits between interrupt/event sources and a single consumer, e.g. a controller servicing one event per handshake.

Parameters:
- N, 8, number of request inputs (N >= 1).
- W, (N>1 ? $clog2(N) : 1), index width. Derived localparam; never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  request event per source, sampled each rising edge
- rr_mode  input  1  0 = fixed priority, 1 = round-robin; quasi-static
- out_valid  output  1  out_idx holds a pending source
- out_ready  input  1  consumer accepts out_idx when out_valid is high
- out_idx  output  W  index of the selected source
- pend  output  N  registered pending vector (status)
- overrun  output  1  one-cycle pulse: request arrived for an already-pending source

Behaviour:
- Reset (async, rst_n low): pend, out_valid, out_idx, rr pointer (ptr) and overrun all clear to 0 immediately, without a clock edge. Events pending at reset are discarded.
- Accept: an accept occurs on an edge where out_valid and out_ready are both high. It clears pend[out_idx] and loads ptr <= out_idx.
- Setting pending bits: at each edge, pend[i] <= 1 if req[i]. A set takes priority over a clear for the same bit in the same cycle.
- Output register load:
  - Loads when out_valid is low, or when an accept occurs.
  - Selection source: pend_eff = pend with the accepted bit cleared. Requests arriving in the same cycle are not included.
  - out_valid <= |pend_eff; out_idx <= select(pend_eff). out_idx keeps its old value if pend_eff == 0.
- Stability: while out_valid is high and out_ready is low, out_idx and out_valid hold. A selection is never retracted, even if a higher-priority request arrives.
- Latency:
  - req high at edge t → pend visible after t → out_valid high after edge t+1.
  - Back-to-back accepts give one index per cycle.
- Fixed select: highest set index wins.
- Round-robin select: search ptr-1, ptr-2, … down to 0, then N-1 … ptr, wrapping modulo N. After reset (ptr = 0) the order is N-1 first, identical to fixed mode.
- rr_mode changes take effect at the next load. ptr updates on every accept regardless of mode.
- overrun <= |(req & pend & ~clear_mask), registered, one cycle.
- N = 1: out_idx is a constant 0. Round-robin degenerates to fixed.

Optional Feature:
- PRIO_MASK_EN defined:
  - Adds input mask [N-1:0].
  - Masked sources still latch into pend and still raise overrun, but are excluded from selection.
  - Masking a source that is already presented does not retract it.
  - Unmasking makes the source eligible at the next load.
- PRIO_MASK_EN undefined: no mask port; all pending bits are eligible.

Decomposition:
- Shared package prio_pkg: localparam MODE_FIXED = 1'b0, MODE_RR = 1'b1, and function idx_w(N).
- Sub-module prio_enc_n:
  - Combinational, parametrised on N.
  - Takes vector and start pointer; returns index and found flag using a wrap-around search.
  - Fixed mode drives start = 0, which gives N-1 first.

Test Plan (N = 8):
- Reset, then req = 0 for 10 cycles → out_valid = 0, pend = 0, overrun = 0 throughout.
- Fixed mode, out_ready = 1, req = 8'b1000_1001 for one cycle → out_idx 7, 3, 0 on consecutive cycles, out_valid low on the 4th; pend drains to 0.
- Fixed mode, out_ready = 0, req = 8'h24 → out_idx = 5 held. Then req[7] pulses → out_idx stays 5, pend = 8'hA4. Then out_ready = 1 → out_idx 7 then 2.
- req held 8'hFF, out_ready = 1:
  - rr_mode = 1 → out_idx 7, 6, 5, … 0, 7 repeating.
  - rr_mode = 0 → out_idx 7 every cycle; overrun high every cycle after the first two.
- req[3] pulsed twice three cycles apart with out_ready = 0 → single-cycle overrun pulse after the second pulse; pend[3] = 1.
- rst_n driven low mid-cycle while out_valid = 1 → out_valid, pend and out_idx go to 0 before the next clk edge.

Source files
------------

// File: rtl/prio_pkg.sv
// Shared definitions for the prio_enc_arb block: mode encodings and the
// index-width helper used by the arbiter and its priority encoder.
package prio_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for an N-entry vector; a single source still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational wrap-around priority encoder.
// Search order starts at start-1 and walks downwards, wrapping modulo N, so
// start = 0 gives the plain "highest index wins" order.
module prio_enc_n
  import prio_pkg::*;
#(
  parameter int N = 8,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  if (N == 1) begin : g_single
    // One source: the index is always 0, only the found flag carries information.
    always_comb begin
      idx   = '0;
      found = vec[0];
    end
  end else begin : g_multi
    int          pos;
    logic [W-1:0] pos_w;

    // Walk the search order from its far end so the earliest candidate is assigned last and wins.
    always_comb begin
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      pos_w = '0;
      for (int k = N; k >= 1; k--) begin
        pos   = (int'(start) + N - k) % N;
        pos_w = W'(pos);
        if (vec[pos_w]) begin
          idx   = pos_w;
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prio_enc_arb.sv
// Registered priority/round-robin arbiter for single-cycle request events.
// Requests are latched into a pending vector; one pending index at a time is
// offered on a valid/ready output and cleared when the consumer accepts it.
// Optional build macro PRIO_MASK_EN adds a mask input that hides pending
// sources from selection without stopping them from latching.
module prio_enc_arb
  import prio_pkg::*;
#(
  parameter int N = 8,
  localparam int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         rr_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pend,
  output logic         overrun
`ifdef PRIO_MASK_EN
  ,
  input  logic [N-1:0] mask
`endif
);

  logic         accept;
  logic         load;
  logic [N-1:0] clear_mask;
  logic [N-1:0] pend_eff;
  logic [N-1:0] elig;
  logic [W-1:0] ptr;
  logic [W-1:0] start;
  logic [W-1:0] sel_idx;
  logic         sel_found;

  assign accept = out_valid & out_ready;
  assign load   = ~out_valid | accept;

  // One-hot of the index being accepted this cycle (all zero when no accept).
  always_comb begin
    clear_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (accept && (out_idx == W'(i))) clear_mask[i] = 1'b1;
    end
  end

  assign pend_eff = pend & ~clear_mask;

`ifdef PRIO_MASK_EN
  assign elig = pend_eff & ~mask;
`else
  assign elig = pend_eff;
`endif

  // Fixed mode searches from 0, i.e. highest index first; round-robin from the last accepted index.
  assign start = (rr_mode == MODE_RR) ? ptr : '0;

  prio_enc_n #(.N(N)) u_enc (
    .vec   (elig),
    .start (start),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Pending vector, overrun pulse and round-robin pointer; a new request beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      overrun <= 1'b0;
      ptr     <= '0;
    end else begin
      pend    <= pend_eff | req;
      overrun <= |(req & pend & ~clear_mask);
      if (accept) ptr <= out_idx;
    end
  end

  // Output register: reload only when empty or on accept so an offered index is never retracted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else if (load) begin
      out_valid <= sel_found;
      if (sel_found) out_idx <= sel_idx;
    end
  end

endmodule
